bus_dest_loader: RTL and testbench
==================================

Name: bus_dest_loader

Overview:
- Write-side counterpart of the datapath bus source multiplexer: captures the 32-bit bus value into the destination register named by a 5-bit destination code.
- Uses the same code map as the bus source select.
- Owns the GPR bank, HI/LO, Z pair, PC, MDR, OUTPORT and Y.
- Provides a one-entry write holding stage with valid/ready handshake, a PC incrementer, a 64-bit Z load from the ALU, and a sticky illegal-destination flag.

Parameters:
- DW, 32, datapath/bus word width
- NGPR, 16, number of general-purpose registers
- PC_STEP, 1, PC increment amount

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- bus_in  in  DW  bus value to capture
- dest_sel  in  5  destination code, same encoding as bus source select
- ld_valid  in  1  load request
- ld_ready  out  1  loader can accept a request
- commit_hold  in  1  freeze commit of holding stage
- z_ld  in  1  load Z pair from ALU
- alu_result  in  2*DW  {zhi, zlo} source
- pc_inc  in  1  PC += PC_STEP
- gpr_q  out  NGPR*DW  flattened R0..R15, R0 in LSBs
- hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, outport_q, y_q  out  DW each  special registers
- pending  out  1  holding stage occupied
- illegal_dest  out  1  sticky: illegal code accepted

Behaviour:
- Reset (clr_n low, asynchronous): all registers, holding stage, pending, illegal_dest = 0; ld_ready = 1 after release.
- Destination code map:
  - 0–15: R0–R15
  - 16: HI; 17: LO; 18: ZHI; 19: ZLO
  - 20: PC; 21: MDR; 22: OUTPORT; 24: Y
  - 23 (sign-extend source) and 25–31 are illegal.
- Accept: ld_valid && ld_ready at edge N. {bus_in, dest_sel} is captured into the holding stage and pending = 1 after edge N.
- Commit: pending && !commit_hold at edge M. The target register gets the held value and pending clears, unless a new request is accepted at the same edge.
- Minimum latency: request at edge N, visible on the *_q output after edge N+1.
- ld_ready = !pending || !commit_hold. This gives back-to-back throughput of one load per cycle.
- commit_hold with pending: ld_ready = 0; the holding stage keeps its contents indefinitely.
- Illegal code accepted: commits nothing, sets illegal_dest at the commit edge. illegal_dest stays set until reset.
- z_ld: zhi_q <= alu_result[2DW-1:DW], zlo_q <= alu_result[DW-1:0]. If a commit to ZHI/ZLO occurs on the same edge, the commit wins for that half only.
- pc_inc: pc_q <= pc_q + PC_STEP, modulo 2^DW (0xFFFFFFFF wraps to 0). A same-edge commit to PC wins and the increment is dropped.
- Reset asserted mid-operation discards the held entry; no partial commit.

Optional Feature:
- Macro LOADER_BYPASS_EN.
- Defined: each *_q output is forwarded combinationally from the holding stage when pending && !commit_hold && the held code targets that register, so a value is visible one cycle earlier.
  - Z bypass yields to z_ld.
  - PC bypass overrides the increment.
- Undefined: outputs are pure register outputs.

Decomposition:
- Shared package bus_pkg holds:
  - the 5-bit destination/source code constants (SEL_R0..SEL_R15, SEL_HI, SEL_LO, SEL_ZHI, SEL_ZLO, SEL_PC, SEL_MDR, SEL_INPORT/SEL_OUTPORT, SEL_SEXT, SEL_Y)
  - DW
  - a function is_writable(code)
- The source mux is retargeted to these constants.
- One sub-module, dest_decode: combinational 5-bit code to one-hot write enables plus an illegal bit, instantiated once.

Test Plan:
1. Reset then load: dest_sel=5, bus_in=0xDEADBEEF, ld_valid for 1 cycle -> R5 = 0xDEADBEEF one edge after accept; pending pulses 1 cycle; all other registers 0.
2. Back-to-back: codes 0,1,16,24 with values 0x11,0x22,0x33,0x44 on consecutive cycles, ld_ready held 1 -> R0=0x11, R1=0x22, HI=0x33, Y=0x44, each one edge after its accept.
3. Stall: load R3=0xA5 then commit_hold=1 for 3 cycles -> ld_ready=0, R3 unchanged; release -> R3=0xA5 at the next edge, ld_ready returns to 1.
4. Conflicts:
   - pc_q=0xFFFFFFFF with pc_inc -> pc_q=0
   - same edge as a commit of PC=0x100 with pc_inc -> pc_q=0x100
   - z_ld with alu_result=0x1_00000002 on the same edge as a ZLO commit of 0x7 -> zhi_q=1, zlo_q=7
5. Illegal: accept dest_sel=23 -> no register changes, illegal_dest=1 and stays 1 through later legal loads; clr_n low clears it asynchronously.
6. Mid-op reset: accept R7=0x55, assert clr_n low before commit -> R7=0, pending=0; with LOADER_BYPASS_EN, R7 output shows 0x55 in the accept-plus-one cycle before the commit edge.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared 5-bit bus source/destination code map, word width and write-enable bundle.
// Rev 1.0
`default_nettype none
package bus_pkg;

  localparam int DW = 32;

  localparam logic [4:0] SEL_R0      = 5'd0;
  localparam logic [4:0] SEL_R1      = 5'd1;
  localparam logic [4:0] SEL_R2      = 5'd2;
  localparam logic [4:0] SEL_R3      = 5'd3;
  localparam logic [4:0] SEL_R4      = 5'd4;
  localparam logic [4:0] SEL_R5      = 5'd5;
  localparam logic [4:0] SEL_R6      = 5'd6;
  localparam logic [4:0] SEL_R7      = 5'd7;
  localparam logic [4:0] SEL_R8      = 5'd8;
  localparam logic [4:0] SEL_R9      = 5'd9;
  localparam logic [4:0] SEL_R10     = 5'd10;
  localparam logic [4:0] SEL_R11     = 5'd11;
  localparam logic [4:0] SEL_R12     = 5'd12;
  localparam logic [4:0] SEL_R13     = 5'd13;
  localparam logic [4:0] SEL_R14     = 5'd14;
  localparam logic [4:0] SEL_R15     = 5'd15;
  localparam logic [4:0] SEL_HI      = 5'd16;
  localparam logic [4:0] SEL_LO      = 5'd17;
  localparam logic [4:0] SEL_ZHI     = 5'd18;
  localparam logic [4:0] SEL_ZLO     = 5'd19;
  localparam logic [4:0] SEL_PC      = 5'd20;
  localparam logic [4:0] SEL_MDR     = 5'd21;
  localparam logic [4:0] SEL_INPORT  = 5'd22;
  localparam logic [4:0] SEL_OUTPORT = 5'd22;
  localparam logic [4:0] SEL_SEXT    = 5'd23;
  localparam logic [4:0] SEL_Y       = 5'd24;

  typedef struct packed {
    logic [15:0] gpr;
    logic        hi;
    logic        lo;
    logic        zhi;
    logic        zlo;
    logic        pc;
    logic        mdr;
    logic        outp;
    logic        y;
    logic        illegal;
  } dest_we_t;

  // Code 22 reads INPORT but writes OUTPORT; SEXT is a read-only source.
  function automatic logic is_writable(input logic [4:0] code);
    return (code <= SEL_OUTPORT) || (code == SEL_Y);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dest_decode.sv
// dest_decode: 5-bit destination code to one-hot register write enables plus an illegal flag.
// Rev 1.0
`default_nettype none
module dest_decode
  import bus_pkg::*;
(
  input  logic [4:0] code_i,
  output dest_we_t   we_o
);

  always_comb begin
    we_o = '0;
    if (!is_writable(code_i)) begin
      we_o.illegal = 1'b1;
    end else if (code_i < SEL_HI) begin
      we_o.gpr[code_i[3:0]] = 1'b1;
    end else begin
      case (code_i)
        SEL_HI:      we_o.hi   = 1'b1;
        SEL_LO:      we_o.lo   = 1'b1;
        SEL_ZHI:     we_o.zhi  = 1'b1;
        SEL_ZLO:     we_o.zlo  = 1'b1;
        SEL_PC:      we_o.pc   = 1'b1;
        SEL_MDR:     we_o.mdr  = 1'b1;
        SEL_OUTPORT: we_o.outp = 1'b1;
        SEL_Y:       we_o.y    = 1'b1;
        default:     we_o.illegal = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_dest_loader.sv
// bus_dest_loader: bus write side with one-entry holding stage, PC incrementer and Z pair load.
// Build option LOADER_BYPASS_EN forwards the committing value to the outputs one cycle early. Rev 1.0
`default_nettype none
module bus_dest_loader #(
  parameter int DW      = 32,
  parameter int NGPR    = 16,
  parameter int PC_STEP = 1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [DW-1:0]        bus_in,
  input  logic [4:0]           dest_sel,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic                 commit_hold,
  input  logic                 z_ld,
  input  logic [2*DW-1:0]      alu_result,
  input  logic                 pc_inc,
  output logic [NGPR*DW-1:0]   gpr_q,
  output logic [DW-1:0]        hi_q,
  output logic [DW-1:0]        lo_q,
  output logic [DW-1:0]        zhi_q,
  output logic [DW-1:0]        zlo_q,
  output logic [DW-1:0]        pc_q,
  output logic [DW-1:0]        mdr_q,
  output logic [DW-1:0]        outport_q,
  output logic [DW-1:0]        y_q,
  output logic                 pending,
  output logic                 illegal_dest
);
  import bus_pkg::*;

`ifdef LOADER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          pending_q, pending_d;
  logic          illegal_q, illegal_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [4:0]    hold_code_q, hold_code_d;
  logic          accept, commit;
  dest_we_t      dec_we, wr;

  logic [DW-1:0] hi_reg_q, lo_reg_q, zhi_reg_q, zlo_reg_q;
  logic [DW-1:0] pc_reg_q, mdr_reg_q, outport_reg_q, y_reg_q;

  assign ld_ready = !pending_q || !commit_hold;
  assign commit   = pending_q && !commit_hold;
  assign accept   = ld_valid && ld_ready;

  dest_decode u_dest_decode (
    .code_i (hold_code_q),
    .we_o   (dec_we)
  );

  assign wr = commit ? dec_we : '0;

  // A same-edge accept refills the stage the commit is draining.
  always_comb begin
    pending_d   = pending_q;
    illegal_d   = illegal_q;
    hold_data_d = hold_data_q;
    hold_code_d = hold_code_q;
    if (commit) begin
      pending_d = 1'b0;
      if (dec_we.illegal) illegal_d = 1'b1;
    end
    if (accept) begin
      pending_d   = 1'b1;
      hold_data_d = bus_in;
      hold_code_d = dest_sel;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pending_q   <= 1'b0;
      illegal_q   <= 1'b0;
      hold_data_q <= '0;
      hold_code_q <= '0;
    end else begin
      pending_q   <= pending_d;
      illegal_q   <= illegal_d;
      hold_data_q <= hold_data_d;
      hold_code_q <= hold_code_d;
    end
  end

  for (genvar i = 0; i < NGPR; i++) begin : g_gpr
    logic [DW-1:0] r_q;
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)         r_q <= '0;
      else if (wr.gpr[i]) r_q <= hold_data_q;
    end
    assign gpr_q[i*DW +: DW] = (BYPASS && wr.gpr[i]) ? hold_data_q : r_q;
  end

  // Commits take priority over z_ld and pc_inc, per affected register only.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hi_reg_q      <= '0;
      lo_reg_q      <= '0;
      zhi_reg_q     <= '0;
      zlo_reg_q     <= '0;
      pc_reg_q      <= '0;
      mdr_reg_q     <= '0;
      outport_reg_q <= '0;
      y_reg_q       <= '0;
    end else begin
      if (wr.hi)   hi_reg_q      <= hold_data_q;
      if (wr.lo)   lo_reg_q      <= hold_data_q;
      if (wr.mdr)  mdr_reg_q     <= hold_data_q;
      if (wr.outp) outport_reg_q <= hold_data_q;
      if (wr.y)    y_reg_q       <= hold_data_q;
      if (wr.zhi)     zhi_reg_q <= hold_data_q;
      else if (z_ld)  zhi_reg_q <= alu_result[2*DW-1:DW];
      if (wr.zlo)     zlo_reg_q <= hold_data_q;
      else if (z_ld)  zlo_reg_q <= alu_result[DW-1:0];
      if (wr.pc)       pc_reg_q <= hold_data_q;
      else if (pc_inc) pc_reg_q <= pc_reg_q + DW'(PC_STEP);
    end
  end

  assign hi_q      = (BYPASS && wr.hi)           ? hold_data_q : hi_reg_q;
  assign lo_q      = (BYPASS && wr.lo)           ? hold_data_q : lo_reg_q;
  assign zhi_q     = (BYPASS && wr.zhi && !z_ld) ? hold_data_q : zhi_reg_q;
  assign zlo_q     = (BYPASS && wr.zlo && !z_ld) ? hold_data_q : zlo_reg_q;
  assign pc_q      = (BYPASS && wr.pc)           ? hold_data_q : pc_reg_q;
  assign mdr_q     = (BYPASS && wr.mdr)          ? hold_data_q : mdr_reg_q;
  assign outport_q = (BYPASS && wr.outp)         ? hold_data_q : outport_reg_q;
  assign y_q       = (BYPASS && wr.y)            ? hold_data_q : y_reg_q;

  assign pending      = pending_q;
  assign illegal_dest = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_dest_loader.sv
// tb_bus_dest_loader: table vectors, directed corner sequences and random traffic vs a register-file model.
// Rev 1.0
`default_nettype none
module tb_bus_dest_loader;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic [31:0]   bus_in = '0;
  logic [4:0]    dest_sel = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic          commit_hold = 1'b0;
  logic          z_ld = 1'b0;
  logic [63:0]   alu_result = '0;
  logic          pc_inc = 1'b0;
  logic [511:0]  gpr_q;
  logic [31:0]   hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, outport_q, y_q;
  logic          pending, illegal_dest;

  bus_dest_loader dut (
    .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .dest_sel(dest_sel),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .commit_hold(commit_hold),
    .z_ld(z_ld), .alu_result(alu_result), .pc_inc(pc_inc), .gpr_q(gpr_q),
    .hi_q(hi_q), .lo_q(lo_q), .zhi_q(zhi_q), .zlo_q(zlo_q), .pc_q(pc_q),
    .mdr_q(mdr_q), .outport_q(outport_q), .y_q(y_q),
    .pending(pending), .illegal_dest(illegal_dest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: register file indexed directly by destination code, plus one held entry.
  logic [31:0] m_reg [32];
  logic        m_pend;
  logic [4:0]  m_code;
  logic [31:0] m_data;
  logic        m_ill;

  function automatic bit legal(input logic [4:0] c);
    return (c != 5'd23) && (c < 5'd25);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pend = 1'b0; m_code = '0; m_data = '0; m_ill = 1'b0;
  endtask

  task automatic model_step();
    logic rdy, com, acc;
    rdy = !m_pend || !commit_hold;
    com = m_pend && !commit_hold;
    acc = ld_valid && rdy;
    if (z_ld) begin
      m_reg[18] = alu_result[63:32];
      m_reg[19] = alu_result[31:0];
    end
    if (pc_inc) m_reg[20] = m_reg[20] + 32'd1;
    if (com) begin
      if (legal(m_code)) m_reg[m_code] = m_data;
      else m_ill = 1'b1;
    end
    if (acc) begin
      m_pend = 1'b1; m_code = dest_sel; m_data = bus_in;
    end else if (com) begin
      m_pend = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_out(input int code);
    logic [31:0] v;
    v = m_reg[code];
`ifdef LOADER_BYPASS_EN
    if (m_pend && !commit_hold && int'(m_code) == code && legal(m_code) &&
        !(z_ld && (code == 18 || code == 19)))
      v = m_data;
`endif
    return v;
  endfunction

  function automatic logic [31:0] dut_out(input int code);
    if (code < 16) return gpr_q[code*32 +: 32];
    case (code)
      16: return hi_q;
      17: return lo_q;
      18: return zhi_q;
      19: return zlo_q;
      20: return pc_q;
      21: return mdr_q;
      22: return outport_q;
      24: return y_q;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ld_ready"}, ld_ready, !m_pend || !commit_hold);
    chk({tag, " pending"}, pending, m_pend);
    chk({tag, " illegal_dest"}, illegal_dest, m_ill);
    for (int c = 0; c < 25; c++)
      if (c != 23) chk($sformatf("%s reg%0d", tag, c), dut_out(c), exp_out(c));
  endtask

  task automatic cycle(input logic v, input logic [4:0] s, input logic [31:0] d,
                       input logic h, input logic z, input logic [63:0] a, input logic p);
    @(negedge clk);
    ld_valid = v; dest_sel = s; bus_in = d; commit_hold = h;
    z_ld = z; alu_result = a; pc_inc = p;
    #1 check_all("pre");
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  s;
    logic [31:0] d;
    logic        h;
    logic        pend;
    logic        rdy;
    int          code;
    logic [31:0] val;
    logic [31:0] val_byp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] want;
    model_reset();
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 5,  32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 5'd0,  32'h11,       1'b0, 1'b1, 1'b1, 0,  32'h0,        32'h11};
    tbl[3]  = '{1'b1, 5'd1,  32'h22,       1'b0, 1'b1, 1'b1, 0,  32'h11,       32'h11};
    tbl[4]  = '{1'b1, 5'd16, 32'h33,       1'b0, 1'b1, 1'b1, 1,  32'h22,       32'h22};
    tbl[5]  = '{1'b1, 5'd24, 32'h44,       1'b0, 1'b1, 1'b1, 16, 32'h33,       32'h33};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 24, 32'h44,       32'h44};
    tbl[7]  = '{1'b1, 5'd3,  32'hA5,       1'b0, 1'b1, 1'b1, 3,  32'h0,        32'hA5};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 3,  32'h0,        32'h0};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 3,  32'h0,        32'h0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 3,  32'h0,        32'h0};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 3,  32'hA5,       32'hA5};
    tbl[12] = '{1'b1, 5'd3,  32'h5A,       1'b0, 1'b1, 1'b1, 3,  32'hA5,       32'h5A};
    tbl[13] = '{1'b1, 5'd4,  32'h77,       1'b1, 1'b1, 1'b0, 3,  32'hA5,       32'hA5};
    tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 3,  32'h5A,       32'h5A};
    tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 4,  32'h0,        32'h0};

    // Reset state
    #3 check_all("reset");
    @(negedge clk); clr_n = 1'b1;

    // Loads, back-to-back traffic and stall
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].h, 1'b0, 64'h0, 1'b0);
`ifdef LOADER_BYPASS_EN
      want = tbl[i].val_byp;
`else
      want = tbl[i].val;
`endif
      chk($sformatf("vec%0d pending", i), pending, tbl[i].pend);
      chk($sformatf("vec%0d ld_ready", i), ld_ready, tbl[i].rdy);
      chk($sformatf("vec%0d reg%0d", i, tbl[i].code), dut_out(tbl[i].code), want);
    end

    // PC wrap and commit-over-increment
    cycle(1'b1, 5'd20, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("pc_load", pc_q, 32'hFFFFFFFF);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1);
    chk("pc_wrap", pc_q, 32'h0);
    cycle(1'b1, 5'd20, 32'h100, 1'b0, 1'b0, 64'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1);
    chk("pc_commit_wins", pc_q, 32'h100);

    // Z load racing a ZLO commit
    cycle(1'b1, 5'd19, 32'h7, 1'b0, 1'b0, 64'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 64'h1_00000002, 1'b0);
    chk("zhi_from_alu", zhi_q, 32'h1);
    chk("zlo_commit_wins", zlo_q, 32'h7);

    // Illegal destination is sticky until reset
    cycle(1'b1, 5'd23, 32'hCAFE, 1'b0, 1'b0, 64'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("illegal_set", illegal_dest, 1'b1);
    cycle(1'b1, 5'd2, 32'h9, 1'b0, 1'b0, 64'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("illegal_sticky", illegal_dest, 1'b1);
    chk("r2_after_illegal", gpr_q[2*32 +: 32], 32'h9);
    @(negedge clk); clr_n = 1'b0; model_reset();
    #1 chk("illegal_async_clear", illegal_dest, 1'b0);
    chk("r2_async_clear", gpr_q[2*32 +: 32], 32'h0);
    @(negedge clk); clr_n = 1'b1;

    // Reset between accept and commit
    cycle(1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 64'h0, 1'b0);
`ifdef LOADER_BYPASS_EN
    chk("r7_bypass_early", gpr_q[7*32 +: 32], 32'h55);
`else
    chk("r7_not_yet", gpr_q[7*32 +: 32], 32'h0);
`endif
    @(negedge clk); clr_n = 1'b0; ld_valid = 1'b0; model_reset();
    #1 chk("r7_midop_reset", gpr_q[7*32 +: 32], 32'h0);
    chk("pending_midop_reset", pending, 1'b0);
    @(posedge clk); #1 chk("r7_no_partial_commit", gpr_q[7*32 +: 32], 32'h0);
    @(negedge clk); clr_n = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 7) == 0),
            {$urandom(), $urandom()}, ($urandom_range(0, 5) == 0));
    end
    @(negedge clk);
    ld_valid = 1'b0; commit_hold = 1'b0; z_ld = 1'b0; pc_inc = 1'b0;
    #1 check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
